// File: rtl/imem_fetch_resp.sv
// Instruction-memory fetch responder: one word fetch per req handshake, answered after
// LATENCY wait states, with flush and a program-load port. IMEM_ERR_EN enables the error check.
module imem_fetch_resp #(
  parameter int DEPTH_WORDS = 2048,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds valid and payload stable until that edge; ready may depend on
  // same-cycle inputs (req_ready looks at flush and rsp_ready), valid never depends on ready.

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] rsp_data_q;
  logic [31:0] rsp_addr_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          cap_from_req;
  logic          cap_from_wait;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_data;
  logic          cap_err;
  logic [AW-1:0] cap_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic          unused_bits;

  assign req_ready = !flush && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
  assign accept    = req_valid && req_ready;

  // With zero wait states the accepted address is captured straight from the request.
  assign cap_from_req  = accept && (LATENCY == 0);
  assign cap_from_wait = !flush && (state_q == S_WAIT) && (cnt_q == 4'd1);
  assign cap_addr      = cap_from_req ? req_addr : addr_q;
  assign cap_idx       = cap_addr[AW+1:2];
  assign wr_idx        = prog_addr[AW+1:2];

`ifdef IMEM_ERR_EN
  assign cap_err     = (cap_addr[1:0] != 2'b00) ||
                       ({2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign cap_data    = cap_err ? NOP : mem[cap_idx];
  assign wr_en       = prog_we && ({2'b00, prog_addr[31:2]} < 32'(DEPTH_WORDS));
  assign unused_bits = ^prog_addr[1:0];
`else
  assign cap_err     = 1'b0;
  assign cap_data    = mem[cap_idx];
  assign wr_en       = prog_we;
  assign unused_bits = ^{prog_addr[31:AW+2], prog_addr[1:0],
                         cap_addr[31:AW+2], cap_addr[1:0], NOP};
`endif

  // Non-blocking write against the capture read gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_addr_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        cnt_q   <= LAT4;
        state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
      end else begin
        case (state_q)
          S_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= S_RESP;
            end
          end
          S_RESP: begin
            if (rsp_ready) begin
              state_q <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
      if (cap_from_req || cap_from_wait) begin
        rsp_data_q <= cap_data;
        rsp_addr_q <= cap_addr;
        rsp_err_q  <= cap_err;
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Bench for imem_fetch_resp: three instances (LATENCY 2, 0, 3); a vector table on the
// LATENCY=2 instance plus hand-written back-to-back, flush and async-reset sequences.
module tb_imem_fetch_resp;

  logic        clk;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        flush     [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_data  [3];
  logic [31:0] rsp_addr  [3];
  logic        rsp_err   [3];
  logic        prog_we   [3];
  logic [31:0] prog_addr [3];
  logic [31:0] prog_data [3];
  logic        busy      [3];
  logic [1:0]  dbg_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_fetch_resp #(
      .DEPTH_WORDS(2048),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .flush     (flush[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_addr  (rsp_addr[g]),
      .rsp_err   (rsp_err[g]),
      .prog_we   (prog_we[g]),
      .prog_addr (prog_addr[g]),
      .prog_data (prog_data[g]),
      .busy      (busy[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

`ifdef IMEM_ERR_EN
  localparam logic [31:0] E12_D = 32'h0000_0013;
  localparam logic        E12_E = 1'b1;
  localparam logic [31:0] E2K_D = 32'h0000_0013;
  localparam logic        E2K_E = 1'b1;
  localparam logic [31:0] E0_D  = 32'hCAFE_0000;
`else
  localparam logic [31:0] E12_D = 32'h0050_0093;
  localparam logic        E12_E = 1'b0;
  localparam logic [31:0] E2K_D = 32'hCAFE_0000;
  localparam logic        E2K_E = 1'b0;
  localparam logic [31:0] E0_D  = 32'h0BAD_0BAD;
`endif

  typedef struct {
    logic        we;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        rv;
    logic [31:0] ra;
    logic        fl;
    logic        rr;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_data;
    logic [31:0] e_addr;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t        tv [$];
  logic [31:0] exp_q [$];
  int          checks;
  int          failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int k, input logic we, input logic [31:0] pa, input logic [31:0] pd,
                       input logic rv, input logic [31:0] ra, input logic fl, input logic rr);
    prog_we[k]   = we;
    prog_addr[k] = pa;
    prog_data[k] = pd;
    req_valid[k] = rv;
    req_addr[k]  = ra;
    flush[k]     = fl;
    rsp_ready[k] = rr;
  endtask

  task automatic idle(input int k);
    drive(k, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic we, input logic [31:0] pa, input logic [31:0] pd,
                     input logic rv, input logic [31:0] ra, input logic fl, input logic rr,
                     input logic e_rdy, input logic e_val, input logic [31:0] e_data,
                     input logic [31:0] e_addr, input logic e_err, input logic e_busy);
    vec_t v;
    v.we = we; v.pa = pa; v.pd = pd; v.rv = rv; v.ra = ra; v.fl = fl; v.rr = rr;
    v.e_rdy = e_rdy; v.e_val = e_val; v.e_data = e_data; v.e_addr = e_addr;
    v.e_err = e_err; v.e_busy = e_busy;
    tv.push_back(v);
  endtask

  initial begin
    int nreq;
    int nresp;
    int lat;
    logic seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) idle(k);

    // reset state, checked without any clock dependence
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_valid", k), 32'(rsp_valid[k]), 32'd0);
      chk($sformatf("rst%0d_data", k), rsp_data[k], 32'd0);
      chk($sformatf("rst%0d_addr", k), rsp_addr[k], 32'd0);
      chk($sformatf("rst%0d_err", k), 32'(rsp_err[k]), 32'd0);
      chk($sformatf("rst%0d_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst%0d_state", k), 32'(dbg_state[k]), 32'd0);
      chk($sformatf("rst%0d_ready", k), 32'(req_ready[k]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // LATENCY=2 table: we pa pd rv ra fl rr | rdy val data addr err busy
    add(1, 32'h10,   32'h0050_0093, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 32'h00,   32'hCAFE_0000, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 32'h40,   32'hAAAA_0001, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h10,   0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 0,  0, 1, 32'h0050_0093, 32'h10, 0, 1);
    add(0, 0, 0, 0, 0,        0, 0,  0, 1, 32'h0050_0093, 32'h10, 0, 1);
    add(0, 0, 0, 0, 0,        0, 0,  0, 1, 32'h0050_0093, 32'h10, 0, 1);
    add(0, 0, 0, 0, 0,        0, 0,  0, 1, 32'h0050_0093, 32'h10, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  1, 1, 32'h0050_0093, 32'h10, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h12,   0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 32'h2000, 0, 1,  1, 1, E12_D, 32'h12, E12_E, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  1, 1, E2K_D, 32'h2000, E2K_E, 1);
    add(1, 32'h2000, 32'h0BAD_0BAD, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 32'h0,    0, 1,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 32'h40,   0, 1,  1, 1, E0_D, 32'h0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(1, 32'h40,   32'hBBBB_0002, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 32'h40,   0, 1,  1, 1, 32'hAAAA_0001, 32'h40, 0, 1);
    add(1, 32'h40,   32'hCCCC_0003, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  1, 1, 32'hCCCC_0003, 32'h40, 0, 1);
    add(0, 0, 0, 0, 0,        0, 1,  1, 0, 0, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(0, tv[i].we, tv[i].pa, tv[i].pd, tv[i].rv, tv[i].ra, tv[i].fl, tv[i].rr);
      @(negedge clk);
      chk($sformatf("tv%0d_ready", i), 32'(req_ready[0]), 32'(tv[i].e_rdy));
      chk($sformatf("tv%0d_valid", i), 32'(rsp_valid[0]), 32'(tv[i].e_val));
      chk($sformatf("tv%0d_busy", i), 32'(busy[0]), 32'(tv[i].e_busy));
      if (tv[i].e_val) begin
        chk($sformatf("tv%0d_data", i), rsp_data[0], tv[i].e_data);
        chk($sformatf("tv%0d_addr", i), rsp_addr[0], tv[i].e_addr);
        chk($sformatf("tv%0d_err", i), 32'(rsp_err[0]), 32'(tv[i].e_err));
      end
      next_cycle();
    end
    idle(0);

    // LATENCY=0 back-to-back through the scoreboard
    for (int j = 0; j < 3; j++) begin
      drive(1, 1'b1, 32'(4 * j), 32'h100 + 32'(4 * j), 1'b0, 32'd0, 1'b0, 1'b1);
      next_cycle();
    end
    idle(1);
    nreq  = 0;
    nresp = 0;
    for (int c = 0; c < 7; c++) begin
      drive(1, 1'b0, 32'd0, 32'd0, (nreq < 3), 32'(4 * nreq), 1'b0, 1'b1);
      @(negedge clk);
      chk($sformatf("b2b_c%0d_valid", c), 32'(rsp_valid[1]), 32'(c >= 1 && c <= 3));
      if (nreq < 3) chk($sformatf("b2b_c%0d_ready", c), 32'(req_ready[1]), 32'd1);
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_rsp", rsp_addr[1], 32'hFFFF_FFFF);
        end else begin
          logic [31:0] ea;
          ea = exp_q.pop_front();
          chk($sformatf("b2b_r%0d_addr", nresp), rsp_addr[1], ea);
          chk($sformatf("b2b_r%0d_data", nresp), rsp_data[1], 32'h100 + ea);
        end
        nresp++;
      end
      if (req_valid[1] && req_ready[1]) begin
        exp_q.push_back(req_addr[1]);
        nreq++;
      end
      next_cycle();
    end
    idle(1);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_resp_count", 32'(nresp), 32'd3);

    // LATENCY=3 flush in the second WAIT cycle, coincident request refused
    drive(2, 1'b1, 32'h20, 32'h00A0_0113, 1'b0, 32'd0, 1'b0, 1'b1);
    next_cycle();
    drive(2, 1'b0, 32'd0, 32'd0, 1'b1, 32'h24, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_accept_ready", 32'(req_ready[2]), 32'd1);
    next_cycle();
    idle(2);
    @(negedge clk);
    chk("fl_wait1_state", 32'(dbg_state[2]), 32'd1);
    chk("fl_wait1_busy", 32'(busy[2]), 32'd1);
    next_cycle();
    drive(2, 1'b0, 32'd0, 32'd0, 1'b1, 32'h28, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_coincident_ready", 32'(req_ready[2]), 32'd0);
    next_cycle();
    idle(2);
    @(negedge clk);
    chk("fl_after_ready", 32'(req_ready[2]), 32'd1);
    chk("fl_after_busy", 32'(busy[2]), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid[2] || busy[2]) seen = 1'b1;
    end
    chk("fl_no_response", 32'(seen), 32'd0);
    next_cycle();
    drive(2, 1'b0, 32'd0, 32'd0, 1'b1, 32'h20, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_new_ready", 32'(req_ready[2]), 32'd1);
    next_cycle();
    drive(2, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rsp_valid[2]) begin
        lat = n;
        break;
      end
      next_cycle();
    end
    chk("fl_new_latency", 32'(lat), 32'd4);
    chk("fl_new_data", rsp_data[2], 32'h00A0_0113);
    chk("fl_new_addr", rsp_addr[2], 32'h20);
    chk("fl_new_err", 32'(rsp_err[2]), 32'd0);
    drive(2, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("fl_resp_ready", 32'(req_ready[2]), 32'd0);
    next_cycle();
    idle(2);
    chk("fl_resp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("fl_resp_busy", 32'(busy[2]), 32'd0);
    next_cycle();

    // async reset while holding a response on the LATENCY=2 instance
    drive(0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h10, 1'b0, 1'b0);
    next_cycle();
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    chk("ar_pre_valid", 32'(rsp_valid[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(rsp_valid[0]), 32'd0);
    chk("ar_busy_drop", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk("ar_idle_state", 32'(dbg_state[0]), 32'd0);
    drive(0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h10, 1'b0, 1'b1);
    next_cycle();
    idle(0);
    next_cycle();
    next_cycle();
    chk("ar_mem_valid", 32'(rsp_valid[0]), 32'd1);
    chk("ar_mem_data", rsp_data[0], 32'h0050_0093);
    chk("ar_mem_addr", rsp_addr[0], 32'h10);
    next_cycle();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
Instruction-memory responder serving the fetch requests driven by the PC stage of the core. It accepts one word-fetch address per valid/ready handshake and returns the instruction after a programmable number of wait states. It supports flush on taken branch/jump (br_sel) and a program-load write port for the bench and boot loader. It replaces the ideal zero-latency instruction array so the fetch path can be exercised with realistic memory timing.

Parameters:
DEPTH_WORDS, 2048, number of 32-bit words; power of 2; byte address range 0 .. 4*DEPTH_WORDS-1
LATENCY, 1, wait states between accept and response, 0..15

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept request this cycle
req_addr  input  32  byte address of instruction (PC value)
flush  input  1  discard any in-flight fetch (taken branch)
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  fetched instruction
rsp_addr  output  32  address belonging to rsp_data
rsp_err  output  1  misaligned or out-of-range fetch
prog_we  input  1  program-load write enable
prog_addr  input  32  program-load byte address
prog_data  input  32  program-load word
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; cnt 0; rsp_valid 0; rsp_data 0; rsp_addr 0; rsp_err 0. Memory contents are not reset. Reset mid-fetch drops the fetch; rsp_valid falls immediately.
- FSM states: IDLE, WAIT, RESP. The flush check has the highest priority in every state.
- req_ready = !flush && (state==IDLE || (state==RESP && rsp_ready)).
- Accept (req_valid && req_ready):
  - Latch req_addr.
  - cnt <= LATENCY.
  - Next state: WAIT if LATENCY>0, else RESP.
- WAIT: cnt decrements each cycle; transition to RESP when cnt==1.
- Timing: rsp_valid is first high exactly LATENCY+1 cycles after the accept cycle.
- On entry to RESP:
  - rsp_data captured from mem[addr[log2(DEPTH_WORDS)+1:2]].
  - rsp_addr <= latched addr.
  - rsp_err computed.
- RESP hold: rsp_valid=1; rsp_data, rsp_addr and rsp_err stay stable while !rsp_ready.
- RESP with rsp_ready and no new accept: go to IDLE.
- RESP with rsp_ready and a new accept in the same cycle: back-to-back; new fetch starts per the accept rule.
- flush in any state: next state IDLE, rsp_valid 0 next cycle, cnt 0. No response is produced for the flushed fetch. A request coincident with flush is not accepted.
- prog write: when prog_we is high, mem[prog_addr index] <= prog_data at the clock edge, in any state.
  - Out-of-range write index is ignored.
  - Write and RESP-entry capture on the same word in the same cycle: capture returns the old data (read-before-write).
  - A write before the capture cycle is visible in the response.
- Error: misaligned (req_addr[1:0]!=0) or word index >= DEPTH_WORDS gives rsp_err=1 and rsp_data=32'h0000_0013 (NOP). Still a normal handshake.
- Address arithmetic: unsigned, 32-bit; no wrap of the range check.

Optional Feature:
IMEM_ERR_EN
- Defined: misaligned/out-of-range detection and NOP substitution as above.
- Undefined:
  - rsp_err tied 0.
  - addr[1:0] ignored.
  - Index taken modulo DEPTH_WORDS (upper bits dropped), for reads and prog writes alike.

Test Plan:
1. LATENCY=2. prog write 0x10 <= 32'h0050_0093; fetch 0x10 accepted cycle 0 -> rsp_valid first in cycle 3, rsp_data=32'h0050_0093, rsp_addr=0x10, rsp_err=0.
2. Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> data/addr/err stable, req_ready=0, busy=1; rsp_ready=1 -> IDLE next cycle.
3. LATENCY=0 back-to-back: fetches 0x0, 0x4, 0x8 with rsp_ready=1 -> each accepted in the previous response's cycle; responses in consecutive-accept+1 cycles, in order.
4. Flush: LATENCY=3, flush in the second WAIT cycle -> no rsp_valid ever for that fetch; req_ready=1 the cycle after flush; a new fetch 0x20 then completes normally.
5. IMEM_ERR_EN defined:
  - Fetch 0x12 -> rsp_err=1, rsp_data=0x0000_0013.
  - Fetch 0x2000 (DEPTH 2048) -> rsp_err=1.
  - Undefined: fetch 0x12 returns mem[4], rsp_err=0.
6. Async reset: assert rst_n=0 while in RESP -> rsp_valid=0 without waiting for a clock edge; after release, IDLE, and previously loaded mem[4] still reads 0x0050_0093.
